lfsr_rng_arbiter: RTL



---
 rtl/lfsr_rng_pkg.sv | 49 ++++
 rtl/lfsr_core.sv | 48 ++++
 rtl/lfsr_rng_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_rng_pkg
// Purpose  : Shared types and helpers for the LFSR random-word arbiter.
//            - state_t : arbiter FSM states (IDLE, COLLECT, DELIVER)
//            - rr_pick : round-robin search for the next requester
//            - rr_inc  : pointer increment with wrap
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_rng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // Requesters are carried in an 8-bit vector (upper bits zero) so the
  // helper does not depend on the instantiating module's NUM_REQ.
  localparam int c_MAX_REQ = 8;

  // First set bit of req[n-1:0], searching from ptr upward with wrap.
  // Returns ptr when no bit is set (caller only uses it when req != 0).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < c_MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] rr_inc(input logic [2:0] ptr, input int n);
    int nxt;
    nxt = (int'(ptr) + 1) % n;
    return nxt[2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core
// Purpose  : Free-running Fibonacci LFSR with lock-up guard and optional load.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset (sr <= SEED)
//            load       - load sr from load_value this edge
//            load_value - value to load; zero maps to SEED
//            sr         - current shift register state
//            rand_bit   - output bit, sr[NUM_BITS-1] of the current state
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_core #(
  parameter int                  NUM_BITS = 5,
  parameter logic [NUM_BITS-1:0] TAPS     = 5'h12,
  parameter logic [NUM_BITS-1:0] SEED     = 5'd1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_value,
  output logic [NUM_BITS-1:0] sr,
  output logic                rand_bit
);

  logic [NUM_BITS-1:0] r_sr;
  logic                w_fb;

  assign w_fb     = ^(r_sr & TAPS);
  assign sr       = r_sr;
  assign rand_bit = r_sr[NUM_BITS-1];

  // The all-zero state is a fixed point of the XOR feedback, so it is
  // escaped by reloading SEED on the edge that sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= SEED;
    end else if (load) begin
      r_sr <= (load_value == '0) ? SEED : load_value;
    end else if (r_sr == '0) begin
      r_sr <= SEED;
    end else begin
      r_sr <= {r_sr[NUM_BITS-2:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfsr_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_rng_arbiter
// Purpose  : Shares one LFSR bit stream among NUM_REQ requesters. A
//            round-robin arbiter grants one requester, WORD_BITS successive
//            LFSR bits are shifted into a word (first bit ends in the MSB),
//            and the word is returned with a one-cycle strobe.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            req          - level request per requester
//            reseed_valid - (LFSR_RNG_RESEED_EN only) reseed strobe, IDLE only
//            reseed_value - (LFSR_RNG_RESEED_EN only) new LFSR state, 0 = SEED
//            rsp_valid    - one-hot response strobe to the granted requester
//            rsp_data     - random word, holds last value outside DELIVER
//            busy         - high in COLLECT and DELIVER
// Macro    : LFSR_RNG_RESEED_EN enables the reseed ports.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int                  NUM_BITS  = 5,
  parameter logic [NUM_BITS-1:0] TAPS      = 5'h12,
  parameter logic [NUM_BITS-1:0] SEED      = 5'd1,
  parameter int                  NUM_REQ   = 4,
  parameter int                  WORD_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
`ifdef LFSR_RNG_RESEED_EN
  input  logic                 reseed_valid,
  input  logic [NUM_BITS-1:0]  reseed_value,
`endif
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [WORD_BITS-1:0] rsp_data,
  output logic                 busy
);

  localparam int                 c_CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WORD_BITS - 1);

  state_t               r_state;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_grant;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WORD_BITS-1:0] r_acc;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [WORD_BITS-1:0] r_rsp_data;
  logic                 r_busy;

  logic                 w_rand_bit;
  logic [NUM_BITS-1:0]  w_sr;
  logic                 w_load;
  logic [NUM_BITS-1:0]  w_load_value;
  logic [7:0]           w_req8;
  logic [2:0]           w_pick;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic                 w_req_grant;
  logic [WORD_BITS-1:0] w_acc_next;

`ifdef LFSR_RNG_RESEED_EN
  // Reseed only acts while idle; it also suppresses the grant that cycle.
  assign w_load       = (r_state == IDLE) && reseed_valid;
  assign w_load_value = reseed_value;
`else
  assign w_load       = 1'b0;
  assign w_load_value = SEED;
`endif

  lfsr_core #(
    .NUM_BITS (NUM_BITS),
    .TAPS     (TAPS),
    .SEED     (SEED)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .load_value (w_load_value),
    .sr         (w_sr),
    .rand_bit   (w_rand_bit)
  );

  always_comb begin
    w_req8              = '0;
    w_req8[NUM_REQ-1:0] = req;
  end

  assign w_pick = rr_pick(w_req8, r_rr_ptr, NUM_REQ);

  // One-hot of the latched grant, built by compare to avoid a dynamic
  // index whose width differs from the requester vector.
  always_comb begin
    w_grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_grant_oh[i] = (r_grant == 3'(i));
    end
  end

  assign w_req_grant = |(req & w_grant_oh);

  generate
    if (WORD_BITS > 1) begin : g_acc_wide
      assign w_acc_next = {r_acc[WORD_BITS-2:0], w_rand_bit};
    end else begin : g_acc_one
      assign w_acc_next = w_rand_bit;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_load && (|req)) begin
            r_grant <= w_pick;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= COLLECT;
          end
        end

        COLLECT: begin
          if (!w_req_grant) begin
            // Requester withdrew: drop the partial word, move past it.
            r_rr_ptr <= rr_inc(r_grant, NUM_REQ);
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              // Output registers load here so the strobe and word appear
              // together for the single DELIVER cycle.
              r_rsp_valid <= w_grant_oh;
              r_rsp_data  <= w_acc_next;
              r_state     <= DELIVER;
            end
          end
        end

        DELIVER: begin
          r_rsp_valid <= '0;
          r_rr_ptr    <= rr_inc(r_grant, NUM_REQ);
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end

        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule
`default_nettype wire
